debug_run_ctrl: RTL and testbench

DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

---
 rtl/debug_run_ctrl.sv | 106 ++++++++++
 tb/tb_debug_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_run_ctrl.sv
// Debug run controller: breakpoint halt, single-step and resume.
// Ports: clk/rst_n, break/step controls, pc_addr in; run_en, halted, state, run_cycles out.
module debug_run_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        break_en,
  input  logic [31:0] breakpoint,
  input  logic        one_step_en,
  input  logic        one_step,
  input  logic [31:0] pc_addr,
  output logic        run_en,
  output logic        halted,
  output logic [1:0]  state,
  output logic [31:0] run_cycles
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    HALT = 2'b01,
    STEP = 2'b10
  } state_e;

  state_e      state_q, state_d;
  logic        armed_q, armed_d;
  logic        s1_q, s2_q, s3_q;
  logic [31:0] run_cycles_q, run_cycles_d;

  logic pc_match;
  logic bp_hit;
  logic step_pulse;
  logic resume;

  assign pc_match   = (pc_addr == breakpoint);
  assign bp_hit     = break_en & armed_q & pc_match;
  assign step_pulse = s2_q & ~s3_q;
  assign resume     = ~break_en & ~one_step_en;

  // A breakpoint hit stalls fetch in the same cycle it is seen.
  always_comb begin
    run_en = 1'b0;
    unique case (state_q)
      RUN:     run_en = ~bp_hit;
      STEP:    run_en = 1'b1;
      default: run_en = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (bp_hit || one_step_en)
          state_d = HALT;
      end
      HALT: begin
        if (resume)
          state_d = RUN;
        else if (step_pulse)
          state_d = STEP;
      end
      STEP: begin
        state_d = resume ? RUN : HALT;
      end
      default: state_d = RUN;
    endcase
  end

  // Disarm on the hit so the held instruction can be stepped
  // or resumed; re-arm once the PC leaves the breakpoint.
  always_comb begin
    armed_d = armed_q;
    if (!pc_match)
      armed_d = 1'b1;
    if (state_q == RUN && bp_hit)
      armed_d = 1'b0;
  end

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (run_en)
      run_cycles_d = run_cycles_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      armed_q      <= 1'b1;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      run_cycles_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      armed_q      <= armed_d;
      s1_q         <= one_step;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      run_cycles_q <= run_cycles_d;
    end
  end

  assign state      = state_q;
  assign halted     = (state_q == HALT);
  assign run_cycles = run_cycles_q;

endmodule

// File: tb/tb_debug_run_ctrl.sv
// Directed testbench for debug_run_ctrl.
// Linear stimulus with immediate-assertion checks.
module tb_debug_run_ctrl;

  logic        clk;
  logic        rst_n;
  logic        break_en;
  logic [31:0] breakpoint;
  logic        one_step_en;
  logic        one_step;
  logic [31:0] pc_addr;
  logic        run_en;
  logic        halted;
  logic [1:0]  state;
  logic [31:0] run_cycles;

  int n_total;
  int n_fail;

  debug_run_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .break_en    (break_en),
    .breakpoint  (breakpoint),
    .one_step_en (one_step_en),
    .one_step    (one_step),
    .pc_addr     (pc_addr),
    .run_en      (run_en),
    .halted      (halted),
    .state       (state),
    .run_cycles  (run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_total     = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    break_en    = 1'b0;
    breakpoint  = 32'h0;
    one_step_en = 1'b0;
    one_step    = 1'b0;
    pc_addr     = 32'h0;

    // reset state
    #3;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_cnt", run_cycles, 32'd0);
    chk("rst_run_en", {31'd0, run_en}, 32'd1);
    tick();
    tick();
    chk("rst_cnt_clk", run_cycles, 32'd0);

    // free run
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("free_run_en", {31'd0, run_en}, 32'd1);
      tick();
    end
    chk("free_state", {30'd0, state}, 32'd0);
    chk("free_cnt", run_cycles, 32'd10);

    // breakpoint at 3c
    break_en   = 1'b1;
    breakpoint = 32'h3c;
    for (int i = 0; i < 15; i++) begin
      pc_addr = 32'(i * 4);
      #1;
      chk("pre_bp_run_en", {31'd0, run_en}, 32'd1);
      tick();
    end
    pc_addr = 32'h3c;
    #1;
    chk("bp_hold_run_en", {31'd0, run_en}, 32'd0);
    chk("bp_hold_state", {30'd0, state}, 32'd0);
    tick();
    chk("bp_state", {30'd0, state}, 32'd1);
    chk("bp_halted", {31'd0, halted}, 32'd1);
    chk("bp_cnt", run_cycles, 32'd25);
    tick();
    chk("bp_cnt_stop", run_cycles, 32'd25);
    chk("bp_run_en", {31'd0, run_en}, 32'd0);

    // step off the breakpoint
    one_step = 1'b1;
    #1;
    tick();
    chk("st1_k", {30'd0, state}, 32'd1);
    tick();
    chk("st1_k1", {30'd0, state}, 32'd1);
    chk("st1_k1_en", {31'd0, run_en}, 32'd0);
    tick();
    chk("st1_k2", {30'd0, state}, 32'd2);
    chk("st1_k2_en", {31'd0, run_en}, 32'd1);
    one_step = 1'b0;
    tick();
    chk("st1_k3", {30'd0, state}, 32'd1);
    chk("st1_cnt", run_cycles, 32'd26);
    pc_addr = 32'h40;
    #1;
    chk("st1_40_en", {31'd0, run_en}, 32'd0);
    tick();
    tick();
    tick();
    one_step = 1'b1;
    #1;
    tick();
    tick();
    chk("st2_k1", {30'd0, state}, 32'd1);
    tick();
    chk("st2_k2", {30'd0, state}, 32'd2);
    chk("st2_k2_en", {31'd0, run_en}, 32'd1);
    one_step = 1'b0;
    tick();
    chk("st2_k3", {30'd0, state}, 32'd1);
    chk("st2_cnt", run_cycles, 32'd27);
    pc_addr = 32'h44;

    // resume from halt without a step
    break_en = 1'b0;
    #1;
    tick();
    chk("res1_state", {30'd0, state}, 32'd0);
    chk("res1_en", {31'd0, run_en}, 32'd1);
    chk("res1_cnt", run_cycles, 32'd27);

    // new breakpoint at 50
    breakpoint = 32'h50;
    break_en   = 1'b1;
    pc_addr    = 32'h48;
    #1;
    chk("bp50_48_en", {31'd0, run_en}, 32'd1);
    tick();
    pc_addr = 32'h4c;
    tick();
    pc_addr = 32'h50;
    #1;
    chk("bp50_hold_en", {31'd0, run_en}, 32'd0);
    tick();
    chk("bp50_state", {30'd0, state}, 32'd1);
    chk("bp50_cnt", run_cycles, 32'd29);

    // resume at breakpoint, no re-halt while disarmed
    break_en = 1'b0;
    #1;
    tick();
    chk("res2_state", {30'd0, state}, 32'd0);
    chk("res2_en", {31'd0, run_en}, 32'd1);
    break_en = 1'b1;
    #1;
    chk("disarmed_en", {31'd0, run_en}, 32'd1);
    tick();
    chk("disarmed_state", {30'd0, state}, 32'd0);
    chk("disarmed_cnt", run_cycles, 32'd30);
    pc_addr = 32'h54;
    #1;
    tick();
    pc_addr = 32'h50;
    #1;
    chk("rearmed_en", {31'd0, run_en}, 32'd0);
    break_en = 1'b0;
    #1;
    chk("bp_off_en", {31'd0, run_en}, 32'd1);
    tick();
    chk("run_cnt", run_cycles, 32'd32);
    chk("run_state", {30'd0, state}, 32'd0);

    // single-step mode from reset
    rst_n       = 1'b0;
    one_step_en = 1'b1;
    pc_addr     = 32'h0;
    #1;
    chk("ss_rst_cnt", run_cycles, 32'd0);
    chk("ss_rst_state", {30'd0, state}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ss_first_en", {31'd0, run_en}, 32'd1);
    tick();
    chk("ss_halt", {30'd0, state}, 32'd1);
    chk("ss_halted", {31'd0, halted}, 32'd1);
    one_step = 1'b1;
    #1;
    tick();
    tick();
    chk("ss1_k1", {30'd0, state}, 32'd1);
    tick();
    chk("ss1_k2", {30'd0, state}, 32'd2);
    chk("ss1_en", {31'd0, run_en}, 32'd1);
    tick();
    chk("ss1_k3", {30'd0, state}, 32'd1);
    chk("ss1_cnt", run_cycles, 32'd2);
    tick();
    tick();
    tick();
    tick();
    chk("ss_held_state", {30'd0, state}, 32'd1);
    chk("ss_held_cnt", run_cycles, 32'd2);
    one_step = 1'b0;
    tick();
    tick();
    tick();
    one_step = 1'b1;
    #1;
    tick();
    tick();
    tick();
    chk("ss2_step", {30'd0, state}, 32'd2);

    // async reset while in STEP
    rst_n    = 1'b0;
    one_step = 1'b0;
    #1;
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_cnt", run_cycles, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    tick();
    chk("post_rst_halt", {30'd0, state}, 32'd1);
    tick();
    tick();
    tick();
    tick();
    chk("no_pending_step", {30'd0, state}, 32'd1);
    chk("post_rst_cnt", run_cycles, 32'd1);

    // counter wrap
    force dut.run_cycles_q = 32'hFFFF_FFFE;
    #1;
    release dut.run_cycles_q;
    #1;
    chk("wrap_preset", run_cycles, 32'hFFFF_FFFE);
    one_step_en = 1'b0;
    #1;
    tick();
    chk("wrap_resume", {30'd0, state}, 32'd0);
    chk("wrap_c0", run_cycles, 32'hFFFF_FFFE);
    tick();
    chk("wrap_c1", run_cycles, 32'hFFFF_FFFF);
    tick();
    chk("wrap_c2", run_cycles, 32'd0);
    tick();
    chk("wrap_c3", run_cycles, 32'd1);

    $display("%0d/%0d checks passed",
             n_total - n_fail, n_total);
    $finish;
  end

endmodule
